fp_align_shift: RTL and testbench
=================================

Name: fp_align_shift

Overview:
- Alignment stage directly downstream of the magnitude-compare/detect-large stage in the FP32 add/sub datapath.
- Consumes the larger and smaller exponent and mantissa, plus the swap and equal flags.
- Restores hidden bits and right-shifts the smaller significand by the exponent difference, collecting guard/round/sticky bits.
- The shift is iterative, one SHIFT_STEP per cycle, with valid/ready handshakes on both sides. The output feeds the significand add/sub stage.

Parameters:
- SHIFT_STEP, 1: bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
- SHIFT_CAP, 27: maximum effective shift; the working register width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operands valid
- in_ready  output  1  block can accept an operand set
- l_exponent  input  8  exponent of the larger-magnitude operand
- s_exponent  input  8  exponent of the smaller-magnitude operand
- l_mantissa  input  23  fraction of the larger-magnitude operand
- s_mantissa  input  23  fraction of the smaller-magnitude operand
- swap  input  1  operands were swapped upstream (B larger)
- equal  input  1  magnitudes equal
- out_valid  output  1  aligned result valid
- out_ready  input  1  downstream accepts the result
- out_exponent  output  8  common (effective larger) exponent
- out_l_sig  output  27  {hidden, l_mantissa, 3'b000}
- out_s_sig  output  27  aligned {hidden, s_mantissa, G, R, S}
- out_swap  output  1  registered swap
- out_equal  output  1  registered equal

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, in_ready=1.
  - out_exponent, out_l_sig, out_s_sig, out_swap, out_equal all 0.
  - Internal shift counter and working register cleared.
  - Reset mid-SHIFT or mid-DONE abandons the operation with no output.
- Hidden bit: 1 if exponent != 0, else 0. Effective exponent: 1 if exponent == 0, else exponent. Both rules apply independently to the l and s operands.
- diff = eff_l - eff_s (8-bit unsigned; upstream guarantees non-negative). rem = min(diff, SHIFT_CAP).
- in_ready = (state==IDLE) only; no accept in the same cycle as an output handshake.
- IDLE, on in_valid && in_ready:
  - Register out_exponent=eff_l, out_l_sig, out_swap, out_equal.
  - Load work = {hidden_s, s_mantissa, 3'b000}.
  - Load counter = rem.
  - Next state: SHIFT if rem != 0, else DONE.
- SHIFT, each cycle:
  - k = min(SHIFT_STEP, counter).
  - work = (work >> k), with bit0 ORed with (bit0 of the old work) and all k bits shifted out (sticky).
  - counter -= k. When the counter reaches 0, the next state is DONE.
- DONE:
  - out_valid=1, out_s_sig=work.
  - All outputs are held stable while out_ready=0.
  - On out_ready: out_valid=0 next cycle, state -> IDLE.
- Latency from accept edge to out_valid high: 1 + ceil(rem / SHIFT_STEP) cycles. Minimum 1 (diff=0); at STEP=1, CAP=27 the maximum is 28.
- A shift of >= 27 yields out_s_sig = {26'b0, |original_work}. If the s operand is zero, this is all zeros.
- Inputs are sampled only at the accept edge; input changes at any other time are ignored.
- equal=1 implies diff=0: pass-through, 1-cycle latency.

Test Plan:
- l=127/0, s=126/0, STEP=1 -> accept, out_valid 2 cycles later; out_exponent=0x7F, out_l_sig=0x4000000, out_s_sig=0x2000000.
- l=127, s=123, s_mantissa=0x000001, STEP=1 -> work 0x4000008 >> 4, sticky set; out_s_sig=0x0400001, latency 5. Repeat with STEP=4 -> same value, latency 2.
- l=127, s=90 (diff 37 capped at 27), s_mantissa=0 -> out_s_sig=0x0000001, latency 28 at STEP=1. With s_exponent=0 and s_mantissa=0 -> out_s_sig=0x0000000.
- Subnormal: l_exponent=1, s_exponent=0, s_mantissa=0x400000 -> diff 0, out_s_sig=0x2000000, out_exponent=1, latency 1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs unchanged, in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 next cycle. Toggling in_valid and the inputs during SHIFT has no effect.
- Assert rst_n=0 asynchronously mid-SHIFT -> out_valid=0 and in_ready=1 immediately. Next operand processed correctly with no residual sticky.

Source files
------------

// File: rtl/fp_align_shift.sv
// ---------------------------------------------------------------------------
// fp_align_shift
//   FP32 add/sub alignment stage. Takes the larger/smaller operand pair from
//   the magnitude-compare stage and restores the hidden bits. It then
//   right-shifts the smaller significand by the exponent difference,
//   SHIFT_STEP bits per cycle, and folds every bit shifted out into a sticky
//   LSB. The result is presented to the significand add/sub stage.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        upstream handshake (ready only while idle)
//   l_exponent, l_mantissa     larger-magnitude operand
//   s_exponent, s_mantissa     smaller-magnitude operand
//   swap, equal                flags from compare stage, passed through
//   out_valid / out_ready      downstream handshake
//   out_exponent               effective exponent of the larger operand
//   out_l_sig                  {hidden, l_mantissa, 3'b000}
//   out_s_sig                  aligned {hidden, s_mantissa, G, R, S}
//   out_swap, out_equal        registered flags
// ---------------------------------------------------------------------------
module fp_align_shift #(
  parameter int SHIFT_STEP = 1,
  parameter int SHIFT_CAP  = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  l_exponent,
  input  logic [7:0]  s_exponent,
  input  logic [22:0] l_mantissa,
  input  logic [22:0] s_mantissa,
  input  logic        swap,
  input  logic        equal,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_exponent,
  output logic [26:0] out_l_sig,
  output logic [26:0] out_s_sig,
  output logic        out_swap,
  output logic        out_equal
);

  localparam int W  = 27;
  localparam int CW = $clog2(SHIFT_CAP + 1);

  if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4 && SHIFT_STEP != 8) begin : g_bad_step
    $error("fp_align_shift: SHIFT_STEP must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    work;
  logic [CW-1:0]   cnt;

  // ---- operand decode (combinational, only used at the accept edge) ----
  logic            hid_l, hid_s;
  logic [7:0]      eff_l, eff_s, diff;
  logic [CW-1:0]   rem;
  logic [W-1:0]    ld_work;

  // Subnormals carry no hidden bit but share exponent 1 with the smallest
  // normals, so the effective exponent of a zero field is 1.
  assign hid_l   = |l_exponent;
  assign hid_s   = |s_exponent;
  assign eff_l   = hid_l ? l_exponent : 8'd1;
  assign eff_s   = hid_s ? s_exponent : 8'd1;
  assign diff    = eff_l - eff_s;
  assign rem     = (diff > 8'(SHIFT_CAP)) ? CW'(SHIFT_CAP) : diff[CW-1:0];
  assign ld_work = {hid_s, s_mantissa, 3'b000};

  // ---- one shift step ----
  // Candidates for every legal per-cycle shift amount; the last partial step
  // picks a smaller one so the total never overshoots rem.
  logic [CW-1:0]                k;
  logic [SHIFT_STEP:1][W-1:0]   cand;
  logic [W-1:0]                 work_nxt;

  assign k = (cnt < CW'(SHIFT_STEP)) ? cnt : CW'(SHIFT_STEP);

  for (genvar i = 1; i <= SHIFT_STEP; i++) begin : g_cand
    logic [W-1:0] sh;
    assign sh      = work >> i;
    // work[i-1:0] includes the old sticky bit, so sticky never gets lost.
    assign cand[i] = {sh[W-1:1], sh[0] | (|work[i-1:0])};
  end

  always_comb begin
    work_nxt = cand[1];
    for (int i = 1; i <= SHIFT_STEP; i++) begin
      if (k == CW'(i)) work_nxt = cand[i];
    end
  end

  // ---- control and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_exponent <= '0;
      out_l_sig    <= '0;
      out_s_sig    <= '0;
      out_swap     <= 1'b0;
      out_equal    <= 1'b0;
      work         <= '0;
      cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            out_exponent <= eff_l;
            out_l_sig    <= {hid_l, l_mantissa, 3'b000};
            out_swap     <= swap;
            out_equal    <= equal;
            work         <= ld_work;
            cnt          <= rem;
            in_ready     <= 1'b0;
            if (rem == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_s_sig <= ld_work;
            end else begin
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - k;
          if (cnt == k) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_s_sig <= work_nxt;
          end
        end
        DONE: begin
          // outputs are only ever written on entry, so they hold under stall
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_shift.sv
// Directed bench for fp_align_shift. Two instances (SHIFT_STEP 1 and 4) see
// identical stimulus; each has its own expected-result queue and the monitor
// checks values, latency, stall stability and post-handshake state.
module tb_fp_align_shift;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [7:0]  l_exponent = '0, s_exponent = '0;
  logic [22:0] l_mantissa = '0, s_mantissa = '0;
  logic        swap = 1'b0, equal = 1'b0;

  logic [1:0]       ir, ov, osw, oeq;
  logic [1:0]       ordy = 2'b11;
  logic [1:0][7:0]  oex;
  logic [1:0][26:0] ol, os;

  fp_align_shift #(.SHIFT_STEP(1), .SHIFT_CAP(27)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .l_exponent(l_exponent), .s_exponent(s_exponent),
    .l_mantissa(l_mantissa), .s_mantissa(s_mantissa),
    .swap(swap), .equal(equal), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_exponent(oex[0]), .out_l_sig(ol[0]), .out_s_sig(os[0]),
    .out_swap(osw[0]), .out_equal(oeq[0]));

  fp_align_shift #(.SHIFT_STEP(4), .SHIFT_CAP(27)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .l_exponent(l_exponent), .s_exponent(s_exponent),
    .l_mantissa(l_mantissa), .s_mantissa(s_mantissa),
    .swap(swap), .equal(equal), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_exponent(oex[1]), .out_l_sig(ol[1]), .out_s_sig(os[1]),
    .out_swap(osw[1]), .out_equal(oeq[1]));

  typedef struct {
    logic [7:0]  ex;
    logic [26:0] l, s;
    logic        sw, eq;
    int          lat;
    int          acc;
    int          bp;
  } exp_t;

  exp_t q0[$], q1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // ---- monitor ----
  logic [1:0]       seen = '0, post = '0;
  int               hold [2];
  logic [1:0][7:0]  s_ex;
  logic [1:0][26:0] s_l, s_s;
  logic [1:0]       s_sw, s_eq;

  task automatic mon(input int d);
    exp_t e;
    string p;
    p = (d == 0) ? "s1" : "s4";
    if (post[d]) begin
      post[d] = 1'b0;
      chk({p, " valid_after_hs"}, 32'(ov[d]), 32'd0);
      chk({p, " ready_after_hs"}, 32'(ir[d]), 32'd1);
    end
    if (ov[d]) begin
      if (!seen[d]) begin
        seen[d] = 1'b1;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk({p, " unexpected_output"}, 32'd1, 32'd0);
          e = '{ex: oex[d], l: ol[d], s: os[d], sw: osw[d], eq: oeq[d], lat: 0, acc: cyc, bp: 0};
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk({p, " exponent"}, 32'(oex[d]), 32'(e.ex));
          chk({p, " l_sig"},    32'(ol[d]),  32'(e.l));
          chk({p, " s_sig"},    32'(os[d]),  32'(e.s));
          chk({p, " swap"},     32'(osw[d]), 32'(e.sw));
          chk({p, " equal"},    32'(oeq[d]), 32'(e.eq));
          chk({p, " latency"},  32'(cyc - e.acc + 1), 32'(e.lat));
        end
        s_ex[d] = oex[d]; s_l[d] = ol[d]; s_s[d] = os[d];
        s_sw[d] = osw[d]; s_eq[d] = oeq[d];
        hold[d] = e.bp;
        if (hold[d] > 0) ordy[d] = 1'b0;
      end else begin
        chk({p, " stall_s_sig"}, 32'(os[d]), 32'(s_s[d]));
        chk({p, " stall_l_sig"}, 32'(ol[d]), 32'(s_l[d]));
        chk({p, " stall_misc"}, {22'd0, s_sw[d], s_eq[d], oex[d]}, {22'd0, osw[d], oeq[d], s_ex[d]});
        chk({p, " stall_in_ready"}, 32'(ir[d]), 32'd0);
        if (hold[d] > 0) begin
          hold[d]--;
          if (hold[d] == 0) ordy[d] = 1'b1;
        end
      end
      if (ordy[d]) begin
        post[d] = 1'b1;
        seen[d] = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon(0);
        mon(1);
      end
    end
  end

  // ---- driver ----
  task automatic wait_idle();
    int n = 0;
    while (ir != 2'b11 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ir != 2'b11) chk("wait_in_ready_timeout", 32'(ir), 32'd3);
  endtask

  task automatic send(input logic [7:0] le, input logic [22:0] lm,
                      input logic [7:0] se, input logic [22:0] sm,
                      input logic sw, input logic eq,
                      input logic [7:0] xe, input logic [26:0] xl, input logic [26:0] xs,
                      input int lat1, input int lat4, input int bp, input int tog);
    exp_t e;
    wait_idle();
    l_exponent = le; l_mantissa = lm; s_exponent = se; s_mantissa = sm;
    swap = sw; equal = eq; in_valid = 1'b1;
    @(posedge clk);
    #1;
    e = '{ex: xe, l: xl, s: xs, sw: sw, eq: eq, lat: lat1, acc: cyc, bp: bp};
    q0.push_back(e);
    e.lat = lat4;
    q1.push_back(e);
    for (int i = 0; i < tog; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      l_exponent = 8'($urandom); s_exponent = 8'($urandom);
      l_mantissa = 23'($urandom); s_mantissa = 23'($urandom);
      swap = 1'($urandom); equal = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst out_valid", 32'(ov), 32'd0);
    chk("rst in_ready", 32'(ir), 32'd3);
    chk("rst exponent", 32'(oex), 32'd0);
    chk("rst l_sig s1", 32'(ol[0]), 32'd0);
    chk("rst s_sig s4", 32'(os[1]), 32'd0);
    chk("rst flags", {28'd0, osw, oeq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // diff 1
    send(8'd127, 23'h0, 8'd126, 23'h0, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h2000000, 2, 2, 0, 0);
    // diff 4, sticky from the lone mantissa LSB
    send(8'd127, 23'h0, 8'd123, 23'h1, 1'b1, 1'b0, 8'h7F, 27'h4000000, 27'h0400001, 5, 2, 0, 0);
    // diff 5: STEP=4 takes a full and a partial step
    send(8'd127, 23'h0, 8'd122, 23'h3, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0200001, 6, 3, 0, 0);
    // diff 37 capped to 27, inputs scrambled while shifting
    send(8'd127, 23'h0, 8'd90, 23'h0, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000001, 28, 8, 0, 5);
    // zero s operand, huge diff
    send(8'd127, 23'h0, 8'd0, 23'h0, 1'b1, 1'b0, 8'h7F, 27'h4000000, 27'h0000000, 28, 8, 0, 0);
    // subnormal s vs exponent-1 l: diff 0
    send(8'd1, 23'h1, 8'd0, 23'h400000, 1'b0, 1'b0, 8'h01, 27'h4000008, 27'h2000000, 1, 1, 0, 0);
    // equal magnitudes: pass-through
    send(8'h85, 23'h7FFFFF, 8'h85, 23'h7FFFFF, 1'b0, 1'b1, 8'h85, 27'h7FFFFF8, 27'h7FFFFF8, 1, 1, 0, 0);
    // diff 2 with 5 cycles of backpressure
    send(8'h80, 23'h2AAAAA, 8'h7E, 23'h155555, 1'b1, 1'b0, 8'h80, 27'h5555550, 27'h12AAAAA, 3, 2, 5, 0);

    // reset in the middle of a long shift abandons the operation
    send(8'd127, 23'h0, 8'd100, 23'h7FFFFF, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000001, 28, 8, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(ov), 32'd0);
    chk("midrst in_ready", 32'(ir), 32'd3);
    chk("midrst s_sig", 32'(os[0]), 32'd0);
    void'(q0.pop_back());
    void'(q1.pop_back());
    seen = '0; post = '0; ordy = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // clean operand after the abort: no leftover sticky
    send(8'h90, 23'h0, 8'h90, 23'h0, 1'b0, 1'b0, 8'h90, 27'h4000000, 27'h4000000, 1, 1, 0, 0);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || ir != 2'b11) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain queues", 32'(q0.size() + q1.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
